// File: rtl/gpio_irq_ctrl.sv
// GPIO block: output mux, toggle, synchronised inputs and sticky edge interrupts.
// Registers sit on a simple sel/addr bus with byte/half/word write sizes.
module gpio_irq_ctrl #(
   parameter int NUM_GPIO    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sel,
   input  logic [2:0]          addr,
   input  logic [1:0]          write_n,
   input  logic [1:0]          read_n,
   input  logic [31:0]         data_in,
   output logic [31:0]         data_out,
   input  logic [NUM_GPIO-1:0] gpio_in,
   input  logic [NUM_GPIO-1:0] alt_out,
   output logic [NUM_GPIO-1:0] gpio_out,
   output logic                irq
);

   localparam int N = NUM_GPIO;
   localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

   logic [N-1:0] out_q, out_d;
   logic [N-1:0] out_sel_q, out_sel_d;
   logic [N-1:0] irq_en_q, irq_en_d;
   logic [N-1:0] rise_en_q, rise_en_d;
   logic [N-1:0] fall_en_q, fall_en_d;
   logic [N-1:0] status_q, status_d;
   logic [N-1:0] dly_q;
   logic [SYNC_STAGES-1:0][N-1:0] sync_q;
   logic [2:0]   arm_q, arm_d;
   logic         irq_q, irq_d;

   logic [31:0]  size_m;
   logic [N-1:0] wm, wd, wbits, fin;
   logic [N-1:0] edge_set, clr;
   logic [N-1:0] rd_v;
   logic         wr_en, armed;
   logic         unused_bits;

   always_comb begin
      case (write_n)
         2'b00:   size_m = 32'h0000_00FF;
         2'b01:   size_m = 32'h0000_FFFF;
         2'b10:   size_m = 32'hFFFF_FFFF;
         default: size_m = 32'h0000_0000;
      endcase
   end

   assign wr_en       = sel && (write_n != 2'b11);
   assign wm          = size_m[N-1:0];
   assign wd          = data_in[N-1:0];
   assign wbits       = wd & wm;
   assign unused_bits = ^{data_in, size_m};

   assign fin   = sync_q[SYNC_STAGES-1];
   assign armed = (arm_q == ARM_MAX);
   assign arm_d = armed ? arm_q : arm_q + 3'd1;

   // Edges are ignored until the synchroniser has flushed its reset zeros.
   assign edge_set = armed ?
      ((fin & ~dly_q & rise_en_q) | (~fin & dly_q & fall_en_q)) : '0;
   assign clr      = (wr_en && addr == 3'd6) ? wbits : '0;

   always_comb begin
      out_d     = out_q;
      out_sel_d = out_sel_q;
      irq_en_d  = irq_en_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      if (wr_en) begin
         case (addr)
            3'd0:    out_d     = (out_q & ~wm) | wbits;
            3'd2:    out_sel_d = (out_sel_q & ~wm) | wbits;
            3'd3:    irq_en_d  = (irq_en_q & ~wm) | wbits;
            3'd4:    rise_en_d = (rise_en_q & ~wm) | wbits;
            3'd5:    fall_en_d = (fall_en_q & ~wm) | wbits;
            3'd7:    out_d     = out_q ^ wbits;
            default: ;
         endcase
      end
      status_d = (status_q & ~clr) | edge_set;
      irq_d    = |(status_q & irq_en_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         out_sel_q <= '0;
         irq_en_q  <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         sync_q    <= '0;
         dly_q     <= '0;
         arm_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_sel_q <= out_sel_d;
         irq_en_q  <= irq_en_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
         dly_q     <= fin;
         arm_q     <= arm_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      case (addr)
         3'd0:    rd_v = out_q;
         3'd1:    rd_v = fin;
         3'd2:    rd_v = out_sel_q;
         3'd3:    rd_v = irq_en_q;
         3'd4:    rd_v = rise_en_q;
         3'd5:    rd_v = fall_en_q;
         3'd6:    rd_v = status_q;
         default: rd_v = '0;
      endcase
      data_out = 32'hFFFF_FFFF;
      if (sel) begin
         data_out = '0;
         if (read_n != 2'b11)
            data_out[N-1:0] = rd_v;
      end
   end

   assign gpio_out = (out_q & out_sel_q) | (alt_out & ~out_sel_q);
   assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: an 8-pin and a 16-pin instance
// share one bus; each task checks one feature inline.
module tb_gpio_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic [2:0]  addr;
   logic [1:0]  write_n, read_n;
   logic [31:0] data_in;
   logic [31:0] dout8, dout16;
   logic [7:0]  gin8, alt8, gout8;
   logic [15:0] gin16, alt16, gout16;
   logic        irq8, irq16;
   logic [31:0] r8, r16;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   gpio_irq_ctrl #(.NUM_GPIO(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst(rst), .sel(sel), .addr(addr),
      .write_n(write_n), .read_n(read_n), .data_in(data_in),
      .data_out(dout8), .gpio_in(gin8), .alt_out(alt8),
      .gpio_out(gout8), .irq(irq8)
   );

   gpio_irq_ctrl #(.NUM_GPIO(16), .SYNC_STAGES(2)) dut16 (
      .clk(clk), .rst(rst), .sel(sel), .addr(addr),
      .write_n(write_n), .read_n(read_n), .data_in(data_in),
      .data_out(dout16), .gpio_in(gin16), .alt_out(alt16),
      .gpio_out(gout16), .irq(irq16)
   );

   task automatic bus_wr(input logic [2:0] a, input logic [1:0] sz,
                         input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; addr = a; write_n = sz; read_n = 2'b11; data_in = d;
      @(negedge clk);
      sel = 1'b0; write_n = 2'b11; data_in = '0;
   endtask

   task automatic bus_rd(input logic [2:0] a);
      @(negedge clk);
      sel = 1'b1; addr = a; write_n = 2'b11; read_n = 2'b00;
      #1;
      r8 = dout8; r16 = dout16;
      sel = 1'b0; read_n = 2'b11;
   endtask

   task automatic test_reset;
      rst = 1'b1; gin8 = '0; alt8 = 8'h5A; gin16 = '0; alt16 = 16'h1234;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (gout8 !== 8'h5A) begin
         errors++; $display("FAIL reset_gout8 got %h want 5a", gout8);
      end
      checks++;
      if (gout16 !== 16'h1234) begin
         errors++; $display("FAIL reset_gout16 got %h want 1234", gout16);
      end
      checks++;
      if (irq8 !== 1'b0) begin
         errors++; $display("FAIL reset_irq got %b want 0", irq8);
      end
      bus_rd(3'd0);
      checks++;
      if (r8 !== 32'h0) begin
         errors++; $display("FAIL reset_out got %h want 0", r8);
      end
      bus_rd(3'd6);
      checks++;
      if (r8 !== 32'h0) begin
         errors++; $display("FAIL reset_status got %h want 0", r8);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_mux;
      bus_wr(3'd2, 2'b10, 32'h0F);
      bus_wr(3'd0, 2'b10, 32'hA5);
      alt8 = 8'h3C;
      #1;
      checks++;
      if (gout8 !== 8'h35) begin
         errors++; $display("FAIL mux8 got %h want 35", gout8);
      end
      checks++;
      if (gout16 !== 16'h1235) begin
         errors++; $display("FAIL mux16 got %h want 1235", gout16);
      end
      alt8 = 8'hC3;
      #1;
      checks++;
      if (gout8 !== 8'hC5) begin
         errors++; $display("FAIL mux8_alt got %h want c5", gout8);
      end
   endtask

   task automatic test_size;
      bus_wr(3'd0, 2'b10, 32'hFFFF);
      bus_wr(3'd0, 2'b00, 32'h1200);
      bus_rd(3'd0);
      checks++;
      if (r16 !== 32'hFF00) begin
         errors++; $display("FAIL byte_wr16 got %h want ff00", r16);
      end
      checks++;
      if (r8 !== 32'h00) begin
         errors++; $display("FAIL byte_wr8 got %h want 0", r8);
      end
      bus_wr(3'd7, 2'b01, 32'h00FF);
      bus_rd(3'd0);
      checks++;
      if (r16 !== 32'hFFFF) begin
         errors++; $display("FAIL tog_half16 got %h want ffff", r16);
      end
      checks++;
      if (r8 !== 32'hFF) begin
         errors++; $display("FAIL tog_half8 got %h want ff", r8);
      end
      bus_wr(3'd7, 2'b00, 32'hFF0F);
      bus_rd(3'd0);
      checks++;
      if (r16 !== 32'hFFF0) begin
         errors++; $display("FAIL tog_byte16 got %h want fff0", r16);
      end
      checks++;
      if (r8 !== 32'hF0) begin
         errors++; $display("FAIL tog_byte8 got %h want f0", r8);
      end
      bus_rd(3'd7);
      checks++;
      if (r16 !== 32'h0) begin
         errors++; $display("FAIL tog_read got %h want 0", r16);
      end
      bus_wr(3'd2, 2'b10, 32'hFFFF_FF0F);
      bus_rd(3'd2);
      checks++;
      if (r8 !== 32'h0F) begin
         errors++; $display("FAIL zext8 got %h want 0000000f", r8);
      end
      checks++;
      if (r16 !== 32'hFF0F) begin
         errors++; $display("FAIL zext16 got %h want 0000ff0f", r16);
      end
   endtask

   task automatic test_in;
      @(negedge clk);
      gin8 = 8'h96; sel = 1'b1; addr = 3'd1; read_n = 2'b00;
      @(posedge clk); #1;
      checks++;
      if (dout8 !== 32'h0) begin
         errors++; $display("FAIL in_stage1 got %h want 0", dout8);
      end
      @(posedge clk); #1;
      checks++;
      if (dout8 !== 32'h96) begin
         errors++; $display("FAIL in_stage2 got %h want 96", dout8);
      end
      @(negedge clk);
      sel = 1'b0; read_n = 2'b11; gin8 = '0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_bus;
      for (int a = 0; a < 8; a++) begin
         @(negedge clk);
         sel = 1'b0; addr = 3'(a); read_n = 2'b00;
         #1;
         checks++;
         if (dout8 !== 32'hFFFF_FFFF || dout16 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL nosel_rd a=%0d got %h/%h want ffffffff",
                     a, dout8, dout16);
         end
      end
      @(negedge clk);
      read_n = 2'b11; addr = 3'd0; write_n = 2'b00; data_in = 32'h0;
      @(negedge clk);
      addr = 3'd2; write_n = 2'b10;
      @(negedge clk);
      write_n = 2'b11;
      bus_rd(3'd0);
      checks++;
      if (r16 !== 32'hFFF0 || r8 !== 32'hF0) begin
         errors++; $display("FAIL nosel_wr_out got %h/%h want f0/fff0", r8, r16);
      end
      bus_rd(3'd2);
      checks++;
      if (r16 !== 32'hFF0F) begin
         errors++; $display("FAIL nosel_wr_sel got %h want ff0f", r16);
      end
   endtask

   task automatic test_rise;
      logic [31:0] est;
      logic        eirq;
      bus_wr(3'd5, 2'b10, 32'h00);
      bus_wr(3'd4, 2'b10, 32'h08);
      bus_wr(3'd3, 2'b10, 32'h08);
      bus_rd(3'd6);
      checks++;
      if (r8 !== 32'h0) begin
         errors++; $display("FAIL rise_pre got %h want 0", r8);
      end
      @(negedge clk);
      gin8 = 8'h08; sel = 1'b1; addr = 3'd6; read_n = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         est  = (i >= 3) ? 32'h08 : 32'h0;
         eirq = (i >= 4);
         checks++;
         if (dout8 !== est || irq8 !== eirq) begin
            errors++;
            $display("FAIL rise_lat cyc=%0d got %h/%b want %h/%b",
                     i, dout8, irq8, est, eirq);
         end
      end
      @(negedge clk);
      gin8 = 8'h00;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (dout8 !== 32'h08 || irq8 !== 1'b1) begin
         errors++; $display("FAIL fall_nochg got %h/%b want 08/1", dout8, irq8);
      end
      @(negedge clk);
      sel = 1'b0; read_n = 2'b11;
   endtask

   task automatic test_clear;
      bus_wr(3'd6, 2'b10, 32'h0);
      bus_rd(3'd6);
      checks++;
      if (r8 !== 32'h08) begin
         errors++; $display("FAIL w0_noeff got %h want 08", r8);
      end
      @(negedge clk);
      gin8 = 8'h08;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      sel = 1'b1; addr = 3'd6; write_n = 2'b10; data_in = 32'h08;
      @(posedge clk);
      @(negedge clk);
      write_n = 2'b11; read_n = 2'b00; data_in = '0;
      #1;
      checks++;
      if (dout8 !== 32'h08 || irq8 !== 1'b1) begin
         errors++; $display("FAIL set_wins got %h/%b want 08/1", dout8, irq8);
      end
      sel = 1'b0; read_n = 2'b11;
      bus_wr(3'd6, 2'b10, 32'h08);
      bus_rd(3'd6);
      checks++;
      if (r8 !== 32'h0) begin
         errors++; $display("FAIL w1c got %h want 0", r8);
      end
      checks++;
      if (irq8 !== 1'b0) begin
         errors++; $display("FAIL irq_drop got %b want 0", irq8);
      end
   endtask

   task automatic test_gate;
      bus_wr(3'd3, 2'b10, 32'h0);
      bus_wr(3'd5, 2'b10, 32'h01);
      @(negedge clk);
      gin8 = 8'h09;
      repeat (5) @(negedge clk);
      gin8 = 8'h08;
      repeat (5) @(negedge clk);
      bus_rd(3'd6);
      checks++;
      if (r8 !== 32'h01) begin
         errors++; $display("FAIL gate_status got %h want 01", r8);
      end
      checks++;
      if (irq8 !== 1'b0) begin
         errors++; $display("FAIL gate_irq got %b want 0", irq8);
      end
   endtask

   task automatic test_arm;
      @(negedge clk);
      rst = 1'b1; gin8 = 8'hFF;
      repeat (3) @(negedge clk);
      rst = 1'b0; sel = 1'b1; addr = 3'd4; write_n = 2'b10; data_in = 32'hFF;
      @(negedge clk);
      write_n = 2'b11; data_in = '0; read_n = 2'b00;
      #1;
      checks++;
      if (dout8 !== 32'hFF) begin
         errors++; $display("FAIL arm_rise_en got %h want ff", dout8);
      end
      addr = 3'd6;
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++;
         if (dout8 !== 32'h0) begin
            errors++; $display("FAIL arm_hold cyc=%0d got %h want 0", i, dout8);
         end
         @(negedge clk);
      end
      sel = 1'b0; read_n = 2'b11;
      gin8 = 8'hFE;
      repeat (6) @(negedge clk);
      gin8 = 8'hFF;
      repeat (6) @(negedge clk);
      bus_rd(3'd6);
      checks++;
      if (r8 !== 32'h01) begin
         errors++; $display("FAIL armed_cap got %h want 01", r8);
      end
   endtask

   task automatic test_reset_mid;
      bus_wr(3'd3, 2'b10, 32'h01);
      bus_wr(3'd0, 2'b10, 32'h5A);
      bus_wr(3'd2, 2'b10, 32'hFF);
      #1;
      checks++;
      if (gout8 !== 8'h5A || irq8 !== 1'b1) begin
         errors++; $display("FAIL pre_rst got %h/%b want 5a/1", gout8, irq8);
      end
      @(negedge clk);
      rst = 1'b1; sel = 1'b1; addr = 3'd0; write_n = 2'b10;
      data_in = 32'hFF; gin8 = 8'hFE;
      @(negedge clk);
      rst = 1'b0; write_n = 2'b11; read_n = 2'b00; data_in = '0;
      #1;
      checks++;
      if (dout8 !== 32'h0) begin
         errors++; $display("FAIL rst_mid_out got %h want 0", dout8);
      end
      checks++;
      if (gout8 !== alt8 || irq8 !== 1'b0) begin
         errors++; $display("FAIL rst_mid_pins got %h/%b want %h/0",
                            gout8, irq8, alt8);
      end
      addr = 3'd6;
      #1;
      checks++;
      if (dout8 !== 32'h0) begin
         errors++; $display("FAIL rst_mid_status got %h want 0", dout8);
      end
      sel = 1'b0; read_n = 2'b11;
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; addr = '0; write_n = 2'b11;
      read_n = 2'b11; data_in = '0;
      gin8 = '0; alt8 = '0; gin16 = '0; alt16 = '0;
      test_reset();
      test_mux();
      test_size();
      test_in();
      test_bus();
      test_rise();
      test_clear();
      test_gate();
      test_arm();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 8, number of GPIO channels (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal range 2..3).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sel, input, 1, high when the bus address decodes to this block.
REQ-006 SHALL have port addr, input, 3, register word index (bus address bits [4:2]).
REQ-007 SHALL have port write_n, input, 2, write size: 11 none, 00 byte, 01 half, 10 word.
REQ-008 SHALL have port read_n, input, 2, read request; any value other than 11 is a read.
REQ-009 SHALL have port data_in, input, 32, write data.
REQ-010 SHALL have port data_out, output, 32, read data.
REQ-011 SHALL have port gpio_in, input, NUM_GPIO, asynchronous pin inputs.
REQ-012 SHALL have port alt_out, input, NUM_GPIO, peripheral-function output values.
REQ-013 SHALL have port gpio_out, output, NUM_GPIO, pin outputs.
REQ-014 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-015 Register map by addr: 0 OUT rw, 1 IN ro, 2 OUT_SEL rw, 3 IRQ_EN rw, 4 RISE_EN rw, 5 FALL_EN rw, 6 STATUS read / write-1-to-clear, 7 TOGGLE wo.
REQ-016 A write SHALL take effect only when sel=1 and write_n!=11; byte writes SHALL update bits [7:0] only, half writes bits [15:0] only, word writes all bits; bits at or above NUM_GPIO SHALL be ignored.
REQ-017 Reads SHALL be combinational with zero latency; data_out SHALL be zero-extended above NUM_GPIO; TOGGLE SHALL read 0; data_out SHALL be 0xFFFFFFFF when sel=0.
REQ-018 gpio_out[i] SHALL equal OUT[i] when OUT_SEL[i]=1, otherwise alt_out[i]; the path SHALL be combinational.
REQ-019 A write to TOGGLE SHALL XOR the written bits into OUT, applying the same size masking as REQ-016.
REQ-020 gpio_in SHALL pass through SYNC_STAGES flops; IN SHALL read the final stage.
REQ-021 Edge detection SHALL compare the final synchroniser stage with a one-cycle-delayed copy: rising sets STATUS[i] if RISE_EN[i]; falling sets STATUS[i] if FALL_EN[i].
REQ-022 STATUS bits SHALL be sticky until cleared by writing 1 to STATUS; writing 0 SHALL have no effect.
REQ-023 If an edge and a clear hit the same STATUS bit in the same cycle, set SHALL win.
REQ-024 irq SHALL equal the OR of (STATUS & IRQ_EN), registered, asserting one cycle after the STATUS bit sets.
REQ-025 IRQ_EN SHALL gate irq only; STATUS SHALL still capture edges when IRQ_EN[i]=0.
REQ-026 An arm counter SHALL suppress edge capture for SYNC_STAGES+1 cycles after rst deasserts, so static pin levels at reset never set STATUS.

Reset
REQ-027 While rst=1: OUT, OUT_SEL, IRQ_EN, RISE_EN, FALL_EN, STATUS, synchroniser flops, delayed copy and irq SHALL be 0, and the arm counter SHALL be cleared.
REQ-028 rst asserted mid-operation SHALL clear all state on that clock edge regardless of a simultaneous write or edge; gpio_out SHALL follow alt_out.

Verification
REQ-029 NUM_GPIO=8: with OUT_SEL=0x0F and OUT=0xA5, set alt_out=0x3C -> gpio_out=0x35.
REQ-030 NUM_GPIO=16: word write OUT=0xFFFF, then byte write 0x1200 -> OUT=0xFF00; then TOGGLE half write 0x00FF -> OUT=0xFFFF.
REQ-031 RISE_EN[3]=1 and IRQ_EN[3]=1, with gpio_in[3] going 0->1 -> STATUS=0x08 exactly SYNC_STAGES+1 cycles later and irq=1 one cycle after that; a falling edge SHALL cause no change.
REQ-032 STATUS=0x08 with a write of 0x08 to STATUS in the same cycle as a new rising edge on pin 3 -> STATUS stays 0x08 and irq stays 1.
REQ-033 gpio_in=0xFF held through reset, RISE_EN=0xFF -> STATUS remains 0x00 for 20 cycles after rst deasserts.
REQ-034 sel=0 with any addr -> data_out=0xFFFFFFFF; a write with write_n=00 and sel=0 -> no register changes.
